// File: rtl/count_seq_ctrl_pkg.sv
// Shared types and constants for the count-sequence run controller.
package count_seq_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int LAP_W_DEFAULT = 8;

    // Generator code that marks the end of one loop of the sequence.
    localparam logic [3:0] LAP_CODE       = 4'd1;
    // Highest code the 7-state generator can legally produce.
    localparam logic [3:0] MAX_LEGAL_CODE = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // True for any generator code outside the legal 0..6 range.
    function automatic logic code_illegal(input logic [3:0] code);
        return (code > MAX_LEGAL_CODE);
    endfunction

endpackage

// File: rtl/count_seq_ctrl_tick_div.sv
// Prescaler for the run rate: counts 0..P with P = max(div,1) and flags
// the terminal count. Held at zero whenever clr_i is asserted.
module tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] ONE_C = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] period_s;

    // A divisor of 0 behaves like 1 so the period never drops below 2.
    assign period_s = (div_i == {DIV_W{1'b0}}) ? ONE_C : div_i;

    // '>=' also catches a count left above a freshly lowered divisor.
    assign tick_o = en_i && (cnt_q >= period_s);

    // Next count: zero on clear, wrap at the terminal count, else increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (en_i) begin
            if (cnt_q >= period_s) begin
                cnt_d = {DIV_W{1'b0}};
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Run controller for the 7-state count-sequence generator: turns
// start/stop/step pulses into a registered advance strobe, clears the
// generator at the start of each run, counts laps and flags bad codes.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT,
    parameter int LAP_W = LAP_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             mode,
    input  logic [LAP_W-1:0] lap_limit,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       cq_in,
    output logic             gen_en,
    output logic             gen_clr,
    output logic             busy,
    output logic             done,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err
);

    localparam logic [LAP_W-1:0] LAP_ONE_C = {{(LAP_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    state_e           state_d;
    logic             gen_en_q;
    logic             gen_en_d;
    logic             gen_clr_q;
    logic             gen_clr_d;
    logic             chk_q;
    logic             err_q;
    logic             err_d;
    logic [LAP_W-1:0] lap_q;
    logic [LAP_W-1:0] lap_d;

    logic             run_s;
    logic             tick_s;
    logic             step_ok_s;
    logic             lap_hit_s;
    logic             bad_code_s;
    logic             limit_hit_s;
    logic [LAP_W-1:0] lap_inc_s;

    assign run_s = (state_q == ST_RUN);

    // The prescaler only runs in RUN; any other state leaves it at zero,
    // which covers both CLEAR and the PAUSE -> RUN resume.
    tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (!run_s),
        .en_i   (run_s),
        .div_i  (div),
        .tick_o (tick_s)
    );

    // A step only counts when neither start nor stop accompanies it.
    assign step_ok_s = step && !start && !stop;

    // Check of the code produced by the previous advance.
    assign lap_hit_s   = chk_q && (cq_in == LAP_CODE);
    assign bad_code_s  = chk_q && code_illegal(cq_in);
    assign lap_inc_s   = (lap_q == {LAP_W{1'b1}}) ? lap_q : (lap_q + LAP_ONE_C);
    assign limit_hit_s = lap_hit_s && mode && (lap_limit != {LAP_W{1'b0}})
                         && (lap_inc_s == lap_limit);

    // FSM next state and advance strobe request.
    always_comb begin
        state_d  = state_q;
        gen_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
                gen_en_d = step_ok_s;
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (limit_hit_s) begin
                    state_d = ST_DONE;
                end else if (stop) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                end
                // No advance while the previous one is still unchecked, and
                // none once the run is ending.
                gen_en_d = tick_s && !gen_en_q && !limit_hit_s && !stop;
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
                gen_en_d = step_ok_s;
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gen_en_d = 1'b0;
            end
        endcase
    end

    // Lap counter and sticky error flag; a new run from IDLE wipes both,
    // while CLEAR only wipes the lap count.
    always_comb begin
        lap_d = lap_hit_s ? lap_inc_s : lap_q;
        err_d = err_q || bad_code_s;
        if ((state_q == ST_IDLE) && start && !stop) begin
            lap_d = {LAP_W{1'b0}};
            err_d = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            lap_d = {LAP_W{1'b0}};
        end else begin
            lap_d = lap_d;
        end
    end

    assign gen_clr_d = (state_d == ST_CLEAR);

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gen_en_q  <= 1'b0;
            gen_clr_q <= 1'b0;
            chk_q     <= 1'b0;
            lap_q     <= {LAP_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gen_en_q  <= gen_en_d;
            gen_clr_q <= gen_clr_d;
            chk_q     <= gen_en_q;
            lap_q     <= lap_d;
            err_q     <= err_d;
        end
    end

    assign gen_en  = gen_en_q;
    assign gen_clr = gen_clr_q;
    assign busy    = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign lap_cnt = lap_q;
    assign err     = err_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a small model of the 7-state
// generator (0 -> 2,5,3,4,6,1 loop) driven by gen_en/gen_clr.
module tb_count_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        step;
    logic        mode;
    logic [7:0]  lap_limit;
    logic [15:0] div;
    logic [3:0]  cq_in;
    logic        gen_en;
    logic        gen_clr;
    logic        busy;
    logic        done;
    logic [7:0]  lap_cnt;
    logic        err;

    logic [3:0]  gen_cq;
    logic        force_bad;
    int          gen_cnt;
    int          total;
    int          bad;
    int          p0;

    count_seq_ctrl #(
        .DIV_W (16),
        .LAP_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .step      (step),
        .mode      (mode),
        .lap_limit (lap_limit),
        .div       (div),
        .cq_in     (cq_in),
        .gen_en    (gen_en),
        .gen_clr   (gen_clr),
        .busy      (busy),
        .done      (done),
        .lap_cnt   (lap_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Generator model: clear to 0, advance along the fixed sequence.
    always @(posedge clk) begin
        if (rst || gen_clr) begin
            gen_cq <= 4'd0;
        end else if (gen_en) begin
            case (gen_cq)
                4'd0:    gen_cq <= 4'd2;
                4'd2:    gen_cq <= 4'd5;
                4'd5:    gen_cq <= 4'd3;
                4'd3:    gen_cq <= 4'd4;
                4'd4:    gen_cq <= 4'd6;
                4'd6:    gen_cq <= 4'd1;
                4'd1:    gen_cq <= 4'd2;
                default: gen_cq <= 4'd0;
            endcase
        end
    end

    assign cq_in = force_bad ? 4'd9 : gen_cq;

    // Count advance strobes mid-cycle.
    always @(negedge clk) begin
        if (gen_en) begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        step = 1'b0;
        mode = 1'b0;
        lap_limit = 8'd0;
        div = 16'd3;
        force_bad = 1'b0;

        // Reset, then idle with no inputs.
        cyc(3);
        rst = 1'b0;
        check("rst_gen_en", gen_en, 0);
        check("rst_gen_clr", gen_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lap", lap_cnt, 0);
        check("rst_err", err, 0);
        p0 = gen_cnt;
        cyc(20);
        check("idle_no_pulse", gen_cnt - p0, 0);
        check("idle_busy", busy, 0);

        // Continuous run, div=3 -> period 4.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("clr_gen_clr", gen_clr, 1);
        check("clr_busy", busy, 1);
        cyc(1);
        check("run_gen_clr_low", gen_clr, 0);
        cyc(3);
        check("run_first_early", gen_en, 0);
        cyc(1);
        check("run_first_pulse", gen_en, 1);
        cyc(1);
        check("run_pulse_width", gen_en, 0);
        cyc(3);
        check("run_second_pulse", gen_en, 1);
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("pause_busy", busy, 0);
        p0 = gen_cnt;
        cyc(10);
        check("pause_no_pulse", gen_cnt - p0, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("resume_busy", busy, 1);
        check("resume_no_clr", gen_clr, 0);
        cyc(3);
        check("resume_early", gen_en, 0);
        cyc(1);
        check("resume_pulse", gen_en, 1);
        check("resume_lap", lap_cnt, 0);
        stop = 1'b1;
        cyc(1);
        cyc(1);
        stop = 1'b0;
        check("stop_stop_idle", busy, 0);

        // Lap limit: div=1, mode=1, limit=2 -> 12 advances then DONE.
        div = 16'd1;
        mode = 1'b1;
        lap_limit = 8'd2;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        p0 = gen_cnt;
        cyc(26);
        check("lim_done_early", done, 0);
        check("lim_lap1", lap_cnt, 1);
        cyc(1);
        check("lim_done", done, 1);
        check("lim_lap2", lap_cnt, 2);
        check("lim_pulses", gen_cnt - p0, 12);
        check("lim_busy", busy, 0);
        p0 = gen_cnt;
        cyc(50);
        check("done_quiet", gen_cnt - p0, 0);
        check("done_hold", done, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("done_stop", done, 0);

        // Step mode in PAUSE, then step ignored in RUN.
        mode = 1'b0;
        div = 16'd3;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        p0 = gen_cnt;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            check("step_pulse", gen_en, 1);
            cyc(1);
            check("step_single", gen_en, 0);
        end
        check("step_count", gen_cnt - p0, 3);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        p0 = gen_cnt;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        check("run_step_ignored", gen_en, 0);
        cyc(3);
        check("run_step_no_extra", gen_cnt - p0, 0);
        check("run_step_natural", gen_en, 1);

        // Illegal code on the check cycle.
        force_bad = 1'b1;
        cyc(2);
        force_bad = 1'b0;
        check("bad_err", err, 1);
        check("bad_still_run", busy, 1);
        cyc(4);
        check("bad_run_continues", busy, 1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("err_kept_resume", err, 1);
        stop = 1'b1;
        cyc(2);
        stop = 1'b0;
        check("err_kept_idle", err, 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("err_cleared", err, 0);
        check("lap_cleared", lap_cnt, 0);

        // start+stop together in IDLE.
        cyc(1);
        stop = 1'b1;
        cyc(2);
        check("back_idle", busy, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        check("startstop_busy", busy, 0);
        check("startstop_clr", gen_clr, 0);

        // div=0 behaves as period 2; lap counter saturates.
        div = 16'd0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        check("div0_pulse1", gen_en, 1);
        cyc(1);
        check("div0_gap", gen_en, 0);
        cyc(1);
        check("div0_pulse2", gen_en, 1);
        cyc(118);
        check("sat_lap10", lap_cnt, 10);
        cyc(3200);
        check("sat_lap255", lap_cnt, 255);
        check("sat_err", err, 0);
        check("sat_busy", busy, 1);

        // Reset mid-run.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_lap", lap_cnt, 0);
        check("mid_rst_clr", gen_clr, 0);
        check("mid_rst_gen_en", gen_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
